uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: CLK100MHZ cycles per UART bit (115200 baud at 100 MHz); legal range 8..65535.
REQ-002 Parameter FIFO_DEPTH, default 8: receive FIFO entries; power of two, 2..64.
REQ-003 CLK100MHZ  input  1  sole clock; all state updates on its rising edge.
REQ-004 CPU_RESETN  input  1  asynchronous, active-low reset.
REQ-005 uart_txd_in  input  1  asynchronous serial line from the host; idle high; 8N1, LSB first.
REQ-006 rd_en  input  1  MMIO pop strobe; one pop per cycle when high.
REQ-007 clr_err  input  1  single-cycle pulse that clears the sticky error flags.
REQ-008 rd_data  output  8  byte at the FIFO head (first-word fall-through); 8'h00 when empty.
REQ-009 empty  output  1  FIFO holds zero bytes.
REQ-010 full  output  1  FIFO holds FIFO_DEPTH bytes.
REQ-011 count  output  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-012 overrun  output  1  sticky: a valid byte was dropped because the FIFO was full.
REQ-013 frame_err  output  1  sticky: a stop bit was sampled low.

Function
REQ-014 uart_txd_in SHALL pass through a two-flop synchronizer (reset value 1); the receiver uses only the synchronized value.
REQ-015 Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE -> START when the synchronized line is 0; the bit counter loads CLKS_PER_BIT/2 - 1.
REQ-017 START: when the counter reaches 0, sample the line; 1 -> IDLE (glitch rejected, nothing recorded); 0 -> DATA, counter reloads CLKS_PER_BIT-1.
REQ-018 DATA: sample at each counter expiry and shift in LSB first; after the 8th sample -> STOP.
REQ-019 STOP: sample at counter expiry. If 1: push the byte when not full, otherwise set overrun and drop the byte; -> IDLE. If 0: set frame_err, discard the byte, -> WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE on the first cycle the synchronized line is 1 (prevents a break condition from re-triggering).
REQ-021 A push SHALL be visible on rd_data, empty and count on the cycle after the stop-bit sample.
REQ-022 rd_en while empty SHALL be ignored: no pointer movement and no error.
REQ-023 Simultaneous push and pop: both take effect and count is unchanged; when full, the pop frees the slot so the push is accepted and overrun is not set.
REQ-024 Read and write pointers SHALL be $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
REQ-025 clr_err SHALL clear both sticky flags; if an error event occurs in the same cycle, the flag remains set (set wins).

Reset
REQ-026 CPU_RESETN low SHALL asynchronously force: FSM = IDLE, counters and pointers = 0, shift register = 0, synchronizer flops = 1, overrun = 0, frame_err = 0, empty = 1, full = 0, count = 0, rd_data = 8'h00.
REQ-027 Assertion mid-frame SHALL abandon the frame; after release, reception resumes only at the next falling edge.
REQ-028 Release SHALL take effect at a rising clock edge; deassertion is synchronized externally.

Structure
REQ-029 A shared package `uart_pkg` SHALL hold the FSM state encodings, the 8N1 frame constants (DATA_BITS = 8) and the default CLKS_PER_BIT.
REQ-030 The FIFO SHALL be a separate sub-module, `sync_fifo` (parameterized on width and depth), instantiated once; the receiver FSM lives in uart_rx_fifo.

Verification (CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-031 Send 8'hA5 with a valid stop bit -> empty falls, rd_data = 8'hA5, count = 1, no flags set; pulse rd_en -> empty = 1.
REQ-032 Drive a 5-cycle low glitch on an idle line -> FSM returns to IDLE and the FIFO and flags are unchanged.
REQ-033 Send 8'h3C with stop = 0, hold the line low for 40 cycles, then send 8'h11 -> frame_err = 1; FIFO contains only 8'h11.
REQ-034 Send 5 bytes 8'h01..8'h05 with no reads -> full = 1, overrun = 1, and reads return 01, 02, 03, 04; clr_err clears overrun.
REQ-035 Fill the FIFO, then assert rd_en on the stop-bit sample cycle of a 5th byte 8'h55 -> count stays 4, overrun = 0, and 8'h55 is the last byte read.
REQ-036 Assert CPU_RESETN low during DATA bit 4 -> all outputs return to their reset values immediately; the next full frame, 8'h7E, is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver FSM states,
// 8N1 frame constants and the default bit period (115200 baud at 100 MHz).
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Purpose: single-clock first-word fall-through FIFO with occupancy count.
// Latency: a push is visible at the head on the cycle after it is accepted.
// Backpressure: a push while full is dropped (drop_o) unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rd_dat_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   drop_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok, push_ok;

  // Accept/drop decisions; a pop on a full FIFO makes room for a same-cycle push.
  always_comb begin
    pop_ok  = pop_i && (cnt_q != '0);
    push_ok = push_i && ((cnt_q != FULL_CNT) || pop_ok);
    drop_o  = push_i && !push_ok;
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop_ok  ? rptr_q + 1'b1 : rptr_q;
    cnt_d   = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= push_dat_i;
  end

  assign empty_o  = (cnt_q == '0);
  assign full_o   = (cnt_q == FULL_CNT);
  assign count_o  = cnt_q;
  assign rd_dat_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/uart_rx_fifo.sv
// Purpose: 8N1 UART receiver feeding a receive FIFO with sticky overrun/framing flags.
// Latency: a received byte appears at rd_data the cycle after its stop-bit sample.
// Backpressure: none on the serial line; bytes arriving to a full FIFO are dropped and flagged.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        CLK100MHZ,
  input  logic                        CPU_RESETN,
  input  logic                        uart_txd_in,
  input  logic                        rd_en,
  input  logic                        clr_err,
  output logic [7:0]                  rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        overrun,
  output logic                        frame_err
);

  localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT/2 - 1);
  localparam logic [15:0] BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT    = 3'(DATA_BITS - 1);

  logic      sync1_q, rx_q;
  rx_state_e state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        ovr_q, ovr_d;
  logic        ferr_q, ferr_d;
  logic        push_vld, ferr_set, fifo_drop;

  // Two-flop synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_q <= 1'b1;
      rx_q    <= 1'b1;
    end else begin
      sync1_q <= uart_txd_in;
      rx_q    <= sync1_q;
    end
  end

  // Receiver next-state logic: counter expiry marks the mid-bit sample point.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_vld = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_q) begin
          state_d = ST_START;
          cnt_d   = HALF_RELOAD;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          if (rx_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            cnt_d   = BIT_RELOAD;
            bit_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          shift_d = {rx_q, shift_q[7:1]};
          cnt_d   = BIT_RELOAD;
          if (bit_q == LAST_BIT) state_d = ST_STOP;
          else                   bit_d   = bit_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (rx_q) begin
            push_vld = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky flags: a same-cycle error event overrides the clear.
  always_comb begin
    ovr_d  = (ovr_q  && !clr_err) || fifo_drop;
    ferr_d = (ferr_q && !clr_err) || ferr_set;
  end

  // Receiver and flag state registers.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      ovr_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      ovr_q   <= ovr_d;
      ferr_q  <= ferr_d;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLK100MHZ),
    .rst_ni     (CPU_RESETN),
    .push_i     (push_vld),
    .push_dat_i (shift_q),
    .pop_i      (rd_en),
    .rd_dat_o   (rd_data),
    .empty_o    (empty),
    .full_o     (full),
    .count_o    (count),
    .drop_o     (fifo_drop)
  );

  assign overrun   = ovr_q;
  assign frame_err = ferr_q;

endmodule
